// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: gates a CPU clock-enable from a slow divider tick,
// with a synchronized run switch, a debounced step button and a single PC breakpoint.
module cpu_run_ctrl #(
    parameter int DIV_W = 15,
    parameter int DB_W  = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_e;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);

    run_state_e        state_q, state_d;
    logic              run_s1_q, run_s1_d, run_s2_q, run_s2_d;
    logic              step_s1_q, step_s1_d, step_s2_q, step_s2_d;
    logic              db_level_q, db_level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              bp_skip_q, bp_skip_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;

    logic tick;
    logic step_evt;
    logic bp_hit;

    always_comb begin
        run_s1_d   = run_sw;
        run_s2_d   = run_s1_q;
        step_s1_d  = step_btn;
        step_s2_d  = step_s1_q;

        div_cnt_d  = div_cnt_q + DIV_ONE;
        tick       = &div_cnt_q;

        // Any cycle where the synchronized input agrees with the level restarts the window.
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        step_evt   = 1'b0;
        if (step_s2_q != db_level_q) begin
            if (&db_cnt_q) begin
                db_level_d = step_s2_q;
                step_evt   = step_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end

        bp_hit      = bp_en && (pc == bp_addr) && !bp_skip_q;
        cpu_ce      = tick && (((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP));
        cycle_cnt_d = cycle_cnt_q + (cpu_ce ? 32'd1 : 32'd0);

        // bp_skip lets the instruction sitting on the breakpoint execute once after resume.
        bp_skip_d = bp_skip_q;
        if (cpu_ce && (state_q == ST_RUN)) begin
            bp_skip_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_s2_q) begin
                    state_d   = ST_RUN;
                    bp_skip_d = 1'b1;
                end else if (step_evt) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_s2_q) begin
                    state_d = ST_HALT;
                end else if (tick && bp_hit) begin
                    state_d = ST_BREAK;
                end
            end
            ST_STEP: begin
                if (tick) begin
                    state_d = ST_HALT;
                end
            end
            ST_BREAK: begin
                if (!run_s2_q) begin
                    state_d = ST_HALT;
                end else if (step_evt) begin
                    state_d = ST_STEP;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HALT;
            run_s1_q    <= 1'b0;
            run_s2_q    <= 1'b0;
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            db_level_q  <= 1'b0;
            db_cnt_q    <= '0;
            div_cnt_q   <= '0;
            bp_skip_q   <= 1'b0;
            cycle_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            run_s1_q    <= run_s1_d;
            run_s2_q    <= run_s2_d;
            step_s1_q   <= step_s1_d;
            step_s2_q   <= step_s2_d;
            db_level_q  <= db_level_d;
            db_cnt_q    <= db_cnt_d;
            div_cnt_q   <= div_cnt_d;
            bp_skip_q   <= bp_skip_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q != ST_RUN);
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with a small divider and debounce window: directed vector table,
// hand-written corner sequences and randomized stimulus against a cycle-level reference model.
module tb_cpu_run_ctrl;

  localparam int DIV_W   = 4;
  localparam int DB_W    = 3;
  localparam int DIV_LEN = 1 << DIV_W;
  localparam int DB_WIN  = 1 << DB_W;
  localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_BREAK = 2'd3;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] cycle_cnt;

  cpu_run_ctrl #(.DIV_W(DIV_W), .DB_W(DB_W)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int g_cyc    = 0;
  int ce_seen  = 0;

  // scoreboard: bench cycle numbers at which a cpu_ce pulse is expected
  logic [31:0] exp_q[$];

  // reference model
  logic        run_pipe[$];
  logic        step_pipe[$];
  logic        m_lvl;
  int          m_diff;
  int          m_cyc;
  logic [1:0]  m_state;
  logic        m_skip;
  logic [31:0] m_cnt;

  typedef struct {
    logic        run;
    logic        step;
    logic        bpe;
    logic [31:0] pcv;
    int          n;
    logic [1:0]  st;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (bench cycle %0d)", name, act, exp, g_cyc);
    end
  endtask

  function automatic void model_reset();
    run_pipe  = '{1'b0, 1'b0};
    step_pipe = '{1'b0, 1'b0};
    m_lvl     = 1'b0;
    m_diff    = 0;
    m_cyc     = 0;
    m_state   = S_HALT;
    m_skip    = 1'b0;
    m_cnt     = 32'd0;
    exp_q.delete();
  endfunction

  // One clock: compare at mid-low phase, predict, cross the rising edge, return at falling edge.
  task automatic cycle();
    logic       s_run, s_step, tick, hit, ce, evt, nskip;
    logic [1:0] nxt;
    #1;
    s_run  = run_pipe[0];
    s_step = step_pipe[0];
    tick   = ((m_cyc % DIV_LEN) == DIV_LEN - 1);
    hit    = bp_en && (pc == bp_addr) && !m_skip;
    ce     = tick && (((m_state == S_RUN) && !hit) || (m_state == S_STEP));
    if (ce) exp_q.push_back(g_cyc);

    check("cpu_ce", {31'd0, cpu_ce}, {31'd0, ce});
    check("state", {30'd0, state}, {30'd0, m_state});
    check("halted", {31'd0, halted}, {31'd0, (m_state != S_RUN)});
    check("cycle_cnt", cycle_cnt, m_cnt);
    if (cpu_ce) begin
      ce_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ce_scoreboard: got unexpected pulse at cycle %0d expected none", g_cyc);
      end else begin
        check("ce_scoreboard", g_cyc, exp_q.pop_front());
      end
    end

    evt = 1'b0;
    if (s_step != m_lvl) begin
      if (m_diff + 1 == DB_WIN) begin
        m_lvl  = s_step;
        evt    = s_step;
        m_diff = 0;
      end else begin
        m_diff++;
      end
    end else begin
      m_diff = 0;
    end

    nxt   = m_state;
    nskip = m_skip;
    if (ce && (m_state == S_RUN)) nskip = 1'b0;
    case (m_state)
      S_HALT:  if (s_run) begin nxt = S_RUN; nskip = 1'b1; end else if (evt) nxt = S_STEP;
      S_RUN:   if (!s_run) nxt = S_HALT; else if (tick && hit) nxt = S_BREAK;
      S_STEP:  if (tick) nxt = S_HALT;
      default: if (!s_run) nxt = S_HALT; else if (evt) nxt = S_STEP;
    endcase
    if (ce) m_cnt = m_cnt + 32'd1;

    @(posedge clk_in);
    run_pipe.push_back(run_sw);
    void'(run_pipe.pop_front());
    step_pipe.push_back(step_btn);
    void'(step_pipe.pop_front());
    m_state = nxt;
    m_skip  = nskip;
    m_cyc++;
    g_cyc++;
    @(negedge clk_in);
  endtask

  // Called at a falling edge; asynchronous assertion is checked before any rising edge.
  task automatic reset_pulse();
    reset    = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    #1;
    check("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    check("rst_state", {30'd0, state}, {30'd0, S_HALT});
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    repeat (2) begin
      @(negedge clk_in);
      check("rst_hold_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int ce_before;
    int len;

    reset    = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 32'h10;
    pc       = 32'h0C;
    model_reset();
    @(negedge clk_in);
    reset_pulse();

    // directed vector table, applied back to back from reset
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0C,  5, S_HALT,  32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0C, 42, S_RUN,   32'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0C,  5, S_HALT,  32'd3};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0C, 14, S_HALT,  32'd4};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0C, 12, S_HALT,  32'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 20, S_RUN,   32'd5};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h10, 20, S_BREAK, 32'd5};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h10,  6, S_HALT,  32'd5};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h10, 18, S_RUN,   32'd6};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h10,  4, S_BREAK, 32'd6};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h10, 14, S_HALT,  32'd7};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h10,  2, S_RUN,   32'd7};
    for (int v = 0; v < 12; v++) begin
      run_sw   = vecs[v].run;
      step_btn = vecs[v].step;
      bp_en    = vecs[v].bpe;
      pc       = vecs[v].pcv;
      run_cycles(vecs[v].n);
      check($sformatf("vec%0d_state", v), {30'd0, state}, {30'd0, vecs[v].st});
      check($sformatf("vec%0d_cycle_cnt", v), cycle_cnt, vecs[v].cnt);
    end

    // bouncing step button: exactly one step, one pulse
    reset_pulse();
    bp_en     = 1'b0;
    ce_before = ce_seen;
    step_btn = 1'b1; run_cycles(2);
    step_btn = 1'b0; run_cycles(2);
    step_btn = 1'b1; run_cycles(30);
    step_btn = 1'b0; run_cycles(12);
    check("bounce_ce_count", ce_seen - ce_before, 32'd1);
    check("bounce_state", {30'd0, state}, {30'd0, S_HALT});
    check("bounce_cycle_cnt", cycle_cnt, 32'd1);

    // cycle counter wrap
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle();
    release dut.cycle_cnt_q;
    check("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
    step_btn = 1'b1; run_cycles(30);
    step_btn = 1'b0; run_cycles(12);
    check("wrap_cycle_cnt", cycle_cnt, 32'd0);

    // reset while a step is pending its tick
    step_btn = 1'b1;
    for (int i = 0; i < 40 && m_state != S_STEP; i++) cycle();
    check("mid_step_reached", {30'd0, state}, {30'd0, S_STEP});
    reset_pulse();
    ce_before = ce_seen;
    run_cycles(20);
    check("post_reset_no_ce", ce_seen - ce_before, 32'd0);
    check("post_reset_state", {30'd0, state}, {30'd0, S_HALT});

    // randomized stimulus against the model
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 29) == 0) reset_pulse();
      run_sw   = 1'($urandom_range(0, 1));
      step_btn = 1'($urandom_range(0, 1));
      bp_en    = 1'($urandom_range(0, 1));
      pc       = 32'h0C + 32'($urandom_range(0, 2)) * 32'd4;
      len      = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
        cycle();
      end
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
